// File: rtl/oled_pkg.sv
// Shared opcodes, state encoding and command-sequence length for the OLED
// framebuffer streamer.
package oled_pkg;

  localparam logic [7:0] CMD_SET_COLUMN = 8'h15;
  localparam logic [7:0] CMD_SET_ROW    = 8'h75;
  localparam logic [7:0] CMD_WRITE_RAM  = 8'h5C;

  localparam int unsigned CMD_LEN   = 7;
  localparam int unsigned CMD_IDX_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    FETCH,
    HI,
    LO,
    DONE
  } state_e;

endpackage

// File: rtl/oled_fb_stream.sv
// Streams one full RGB565 frame from a synchronous-read framebuffer to an OLED
// byte bus: a 7-byte window/write command prefix, then high/low byte per pixel.
module oled_fb_stream
  import oled_pkg::*;
#(
  parameter int WIDTH      = 128,
  parameter int HEIGHT     = 128,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  input  logic [15:0]           fb_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_dc,
  output logic [7:0]            out_data
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(WIDTH * HEIGHT - 1);
  localparam logic [CMD_IDX_W-1:0]  LAST_CMD = CMD_IDX_W'(CMD_LEN - 1);

  state_e                 state_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   out_valid_q;
  logic                   out_dc_q;
  logic [7:0]             out_data_q;
  logic [CMD_IDX_W-1:0]   cmd_idx_q;
  logic [ADDR_WIDTH-1:0]  pix_cnt_q;
  logic [ADDR_WIDTH-1:0]  pix_cnt_d;
  logic [15:0]            pixel_q;
  logic                   xfer;

  // Returns {dc, byte} for each position of the column/row window prefix.
  function automatic logic [8:0] cmd_entry(input logic [CMD_IDX_W-1:0] idx);
    logic [8:0] e;
    case (idx)
      3'd0:    e = {1'b0, CMD_SET_COLUMN};
      3'd1:    e = {1'b1, 8'h00};
      3'd2:    e = {1'b1, 8'(WIDTH - 1)};
      3'd3:    e = {1'b0, CMD_SET_ROW};
      3'd4:    e = {1'b1, 8'h00};
      3'd5:    e = {1'b1, 8'(HEIGHT - 1)};
      default: e = {1'b0, CMD_WRITE_RAM};
    endcase
    return e;
  endfunction

  assign xfer = out_valid_q & out_ready;

  // The framebuffer read is registered, so the address leads the counter by one
  // cycle: the pixel is already on fb_dout during FETCH and is latched into HI.
  always_comb begin
    // NOTE: default assignment first keeps this block latch-free.
    pix_cnt_d = pix_cnt_q;
    if (state_q == LO && xfer) begin
      pix_cnt_d = (pix_cnt_q == LAST_PIX) ? '0 : pix_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only, so every register sees pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_dc_q    <= 1'b0;
      out_data_q  <= 8'h00;
      cmd_idx_q   <= '0;
      pix_cnt_q   <= '0;
      pixel_q     <= '0;
    end else begin
      done_q    <= 1'b0;
      pix_cnt_q <= pix_cnt_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q                <= CMD;
            busy_q                 <= 1'b1;
            cmd_idx_q              <= '0;
            out_valid_q            <= 1'b1;
            {out_dc_q, out_data_q} <= cmd_entry('0);
          end
        end
        CMD: begin
          if (xfer) begin
            if (cmd_idx_q == LAST_CMD) begin
              state_q     <= FETCH;
              out_valid_q <= 1'b0;
            end else begin
              cmd_idx_q              <= cmd_idx_q + 1'b1;
              {out_dc_q, out_data_q} <= cmd_entry(cmd_idx_q + 1'b1);
            end
          end
        end
        FETCH: begin
          state_q     <= HI;
          pixel_q     <= fb_dout;
          out_valid_q <= 1'b1;
          out_dc_q    <= 1'b1;
          out_data_q  <= fb_dout[15:8];
        end
        HI: begin
          out_data_q <= xfer ? pixel_q[7:0] : pixel_q[15:8];
          if (xfer) state_q <= LO;
        end
        LO: begin
          if (xfer) begin
            out_valid_q <= 1'b0;
            if (pix_cnt_q == LAST_PIX) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= FETCH;
            end
          end
        end
        DONE: begin
          state_q   <= IDLE;
          cmd_idx_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign fb_addr   = pix_cnt_d;
  assign out_valid = out_valid_q;
  assign out_dc    = out_dc_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_oled_fb_stream.sv
// Self-checking bench for oled_fb_stream on a 4x2 frame with fb[i] = 16'hA000 + i;
// a scoreboard queue holds the expected byte stream of every frame started.
`timescale 1ns/1ps
module tb_oled_fb_stream;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int AW   = 3;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic [AW-1:0] fb_addr;
  logic [15:0]   fb_dout = 16'h0000;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_dc;
  logic [7:0]    out_data;

  typedef struct {
    logic          dc;
    logic [7:0]    data;
    logic          chk_addr;
    logic [AW-1:0] addr;
  } exp_t;

  typedef struct {
    string name;
    bit    rand_ready;
    bit    extra_start;
    int    exp_latency;
    int    exp_dones;
  } vec_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         xfer_cnt = 0;
  int         done_cnt = 0;
  bit         rand_ready = 1'b0;
  logic       prev_stall = 1'b0;
  logic       prev_dc    = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always #5 clk = ~clk;

  oled_fb_stream #(
    .WIDTH     (W),
    .HEIGHT    (H),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .fb_addr  (fb_addr),
    .fb_dout  (fb_dout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_dc   (out_dc),
    .out_data (out_data)
  );

  // Synchronous-read framebuffer model.
  always @(posedge clk) fb_dout <= 16'hA000 + 16'(fb_addr);

  always @(posedge clk) cyc++;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Byte monitor: scoreboard pops, stall stability, done pulses.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", 32'(out_valid), 32'd1);
        check("stall_byte_held", 32'({out_dc, out_data}), 32'({prev_dc, prev_data}));
      end
      if (done) begin
        done_cnt++;
        check("busy_low_in_done", 32'(busy), 32'd0);
      end
      if (out_valid && out_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_byte", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("byte", 32'({out_dc, out_data}), 32'({e.dc, e.data}));
          if (e.chk_addr) check("fb_addr_sweep", 32'(fb_addr), 32'(e.addr));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_dc    = out_dc;
      prev_data  = out_data;
    end
  end

  task automatic push_frame();
    exp_t       e;
    logic [8:0] cmd [7];
    cmd = '{9'h015, 9'h100, 9'h103, 9'h075, 9'h100, 9'h101, 9'h05C};
    for (int i = 0; i < 7; i++) begin
      e.dc = cmd[i][8]; e.data = cmd[i][7:0]; e.chk_addr = 1'b0; e.addr = '0;
      exp_q.push_back(e);
    end
    for (int p = 0; p < NPIX; p++) begin
      e.dc = 1'b1; e.data = 8'hA0; e.chk_addr = 1'b1; e.addr = AW'(p);
      exp_q.push_back(e);
      e.data = 8'(p); e.chk_addr = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_dc"},    32'(out_dc),    32'd0);
    check({tag, "_out_data"},  32'(out_data),  32'd0);
    check({tag, "_fb_addr"},   32'(fb_addr),   32'd0);
  endtask

  task automatic do_reset(input bit with_start, input string tag);
    @(posedge clk);
    #1;
    rst   = 1'b1;
    start = with_start;
    @(posedge clk);
    @(negedge clk);
    check_reset_state(tag);
    rst   = 1'b0;
    start = 1'b0;
  endtask

  // Starts one frame; returns at the negedge of the done cycle (latency in cycles,
  // counting the start cycle as 0) or -1 on timeout.
  task automatic run_frame(input bit rr, input bit xs, output int lat);
    int c0;
    bit got;
    rand_ready = rr;
    @(posedge clk);
    #1;
    start = 1'b1;
    c0    = cyc;
    push_frame();
    @(posedge clk);
    #1;
    start = 1'b0;
    got = 1'b0;
    lat = -1;
    for (int k = 0; k < 2000 && !got; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        lat = cyc - c0;
      end else begin
        start = xs && ((cyc - c0 == 6) || (cyc - c0 == 20));
      end
    end
    start = 1'b0;
    check("done_within_budget", 32'(got), 32'd1);
    if (xs && got) begin
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  initial begin : main
    vec_t vecs[4];
    int   lat;
    int   d0;
    int   base;
    bit   got;

    vecs[0] = '{name: "ready_high",       rand_ready: 1'b0, extra_start: 1'b0, exp_latency: 32, exp_dones: 1};
    vecs[1] = '{name: "backpressure",     rand_ready: 1'b1, extra_start: 1'b0, exp_latency: -1, exp_dones: 1};
    vecs[2] = '{name: "start_ignored",    rand_ready: 1'b0, extra_start: 1'b1, exp_latency: 32, exp_dones: 1};
    vecs[3] = '{name: "bp_start_ignored", rand_ready: 1'b1, extra_start: 1'b1, exp_latency: -1, exp_dones: 1};

    do_reset(1'b0, "reset");

    for (int i = 0; i < 4; i++) begin
      d0 = done_cnt;
      run_frame(vecs[i].rand_ready, vecs[i].extra_start, lat);
      if (vecs[i].exp_latency >= 0)
        check({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].exp_latency));
      rand_ready = 1'b0;
      repeat (6) @(negedge clk);
      check({vecs[i].name, "_done_count"}, 32'(done_cnt - d0), 32'(vecs[i].exp_dones));
      check({vecs[i].name, "_idle_after"}, 32'(busy), 32'd0);
      check({vecs[i].name, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
    end

    // Back-to-back frames: second start lands in the first IDLE cycle after done.
    d0 = done_cnt;
    run_frame(1'b0, 1'b0, lat);
    check("b2b_first_latency", 32'(lat), 32'd32);
    run_frame(1'b0, 1'b0, lat);
    check("b2b_second_latency", 32'(lat), 32'd32);
    repeat (4) @(negedge clk);
    check("b2b_done_count", 32'(done_cnt - d0), 32'd2);
    check("b2b_sb_drained", 32'(exp_q.size()), 32'd0);

    // Reset wins over a simultaneous start.
    do_reset(1'b1, "rst_vs_start");
    repeat (3) @(negedge clk);
    check("rst_vs_start_stays_idle", 32'(busy), 32'd0);

    // Reset right after the 4th pixel byte (11th byte overall) transfers.
    base = xfer_cnt;
    d0   = done_cnt;
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1;
    push_frame();
    @(posedge clk);
    #1;
    start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(posedge clk);
      #1;
      if (xfer_cnt - base >= 11) got = 1'b1;
    end
    check("midrst_reached_byte11", 32'(got), 32'd1);
    check("midrst_bytes_left", 32'(exp_q.size()), 32'd12);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_reset_state("midrst");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_valid_stays_low", 32'(out_valid), 32'd0);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    run_frame(1'b0, 1'b0, lat);
    check("midrst_restart_latency", 32'(lat), 32'd32);
    repeat (3) @(negedge clk);
    check("final_sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/oled_fb_stream.md
OLED_FB_STREAM -- requirements
Module: oled_fb_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 128, meaning frame width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 128, meaning frame height in pixels.
REQ-003 SHALL have parameter ADDR_WIDTH, default 14, meaning framebuffer address width (2**ADDR_WIDTH >= WIDTH*HEIGHT).
REQ-004 SHALL have ports in this order:
- clk  input  1  sole clock, all logic on rising edge.
- rst  input  1  reset; one clock, synchronous, active-high.
- start  input  1  frame request pulse.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse at frame completion.
- fb_addr  output  ADDR_WIDTH  framebuffer read address.
- fb_dout  input  16  RGB565 pixel; synchronous read, valid 1 cycle after fb_addr.
- out_valid  output  1  byte available to downstream OLED bus driver.
- out_ready  input  1  downstream accepts byte.
- out_dc  output  1  0 = command byte, 1 = data byte.
- out_data  output  8  byte value.

Function
REQ-005 SHALL use states IDLE, CMD, FETCH, HI, LO, DONE.
REQ-006 IDLE: start=1 SHALL go to CMD next cycle, set busy=1 and command index=0; start SHALL be ignored in every other state.
REQ-007 CMD SHALL emit 7 bytes in order (dc): 0x15(0), 0x00(1), WIDTH-1(1), 0x75(0), 0x00(1), HEIGHT-1(1), 0x5C(0).
REQ-008 A byte SHALL transfer only on a cycle with out_valid=1 and out_ready=1; while out_valid=1 and out_ready=0, out_data and out_dc SHALL hold stable.
REQ-009 out_valid SHALL be high in CMD, HI and LO only; low in IDLE, FETCH and DONE.
REQ-010 After the 7th command byte transfers, the block SHALL enter FETCH with pixel counter=0.
REQ-011 FETCH SHALL drive fb_addr=pixel counter for one cycle, then enter HI, capturing fb_dout into a pixel register on entry to HI.
REQ-012 HI SHALL present pixel[15:8] with dc=1; on transfer go to LO.
REQ-013 LO SHALL present pixel[7:0] with dc=1; on transfer increment the pixel counter and go to FETCH, or to DONE if the counter was WIDTH*HEIGHT-1.
REQ-014 Pixel order SHALL be row-major, fb_addr = y*WIDTH + x, from 0 to WIDTH*HEIGHT-1, with no skips or repeats.
REQ-015 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE; the pixel counter and fb_addr SHALL return to 0.
REQ-016 With out_ready held high, start-to-done SHALL take exactly 1 + 7 + 3*WIDTH*HEIGHT cycles.
REQ-017 A start asserted in the DONE cycle SHALL be ignored; a start in the first IDLE cycle after DONE SHALL begin a new frame.
REQ-018 Pixel register and counters SHALL be wide enough that WIDTH*HEIGHT-1 does not wrap.

Reset
REQ-019 rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, out_valid=0, out_dc=0, out_data=0x00, fb_addr=0, and pixel/command counters=0.
REQ-020 rst mid-frame SHALL abort without a done pulse; the next start SHALL restart at command byte 0x15.
REQ-021 rst SHALL take priority over start on the same cycle.

Structure
REQ-022 SHALL place the opcodes CMD_SET_COLUMN=0x15, CMD_SET_ROW=0x75 and CMD_WRITE_RAM=0x5C, the state encoding, and the 7-entry command length constant in shared package oled_pkg.
REQ-023 SHALL have no sub-module; the command sequence SHALL be a case on the command index.

Verification (bench WIDTH=4, HEIGHT=2, fb[i]=16'hA000+i)
REQ-024 start, out_ready=1 -> bytes 15 00 03 75 00 01 5C, then A0 00 A0 01 ... A0 07; done pulse at cycle 1+7+24=32.
REQ-025 Random out_ready backpressure -> identical 23-byte stream, out_data/out_dc stable during every stall, exactly one done pulse.
REQ-026 rst after the 4th pixel byte transfers -> out_valid=0 next cycle, no done pulse; a new start emits 0x15 first.
REQ-027 start pulsed during a frame and in the DONE cycle -> ignored; exactly one frame produced.
REQ-028 Two back-to-back frames (start in the first IDLE cycle after done) -> fb_addr sweeps 0..7 twice, with the 7-byte command prefix repeated before each frame.
